// File: rtl/morse_key_decoder.sv
// Morse key decoder: synchronises and debounces a telegraph key, times presses and gaps,
// collects a dot/dash pattern and emits the matching ASCII character with a send strobe.
module morse_key_decoder #(
  parameter int unsigned TICK_DIV         = 1_000_000,
  parameter int unsigned DEBOUNCE_TICKS   = 2,
  parameter int unsigned DOT_MAX_TICKS    = 20,
  parameter int unsigned LETTER_GAP_TICKS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic [7:0] letter,
  output logic       send,
  output logic       busy,
  output logic       error
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    DB_LAST    = 8'(DEBOUNCE_TICKS - 1);
  localparam logic [7:0]    DOT_MAX    = 8'(DOT_MAX_TICKS);
  localparam logic [7:0]    GAP_END    = 8'(LETTER_GAP_TICKS);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

  logic          key_s1_reg, key_s2_reg;
  logic [PW-1:0] presc_reg;
  logic          tick;
  logic          key_db_reg, key_db_prev_reg;
  logic [7:0]    db_cnt_reg;
  logic          rise, fall;

  state_t     state_reg, state_next;
  logic [7:0] dur_reg, dur_next;
  logic [7:0] gap_reg, gap_next;
  logic [4:0] pat_reg, pat_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       ovf_reg, ovf_next;
  logic [7:0] letter_reg, letter_next;
  logic       send_reg, send_next;
  logic       error_reg, error_next;
  logic [7:0] lut_char;
  logic       lut_ok;

  assign tick = (presc_reg == PRESC_LAST);
  assign rise = key_db_reg & ~key_db_prev_reg;
  assign fall = ~key_db_reg & key_db_prev_reg;

  // Front end: synchroniser, tick prescaler and tick-based debounce
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_reg      <= 1'b0;
      key_s2_reg      <= 1'b0;
      presc_reg       <= '0;
      key_db_reg      <= 1'b0;
      key_db_prev_reg <= 1'b0;
      db_cnt_reg      <= 8'd0;
    end else begin
      key_s1_reg      <= key_in;
      key_s2_reg      <= key_s1_reg;
      presc_reg       <= tick ? '0 : presc_reg + PW'(1);
      key_db_prev_reg <= key_db_reg;
      if (key_s2_reg == key_db_reg) begin
        db_cnt_reg <= 8'd0;
      end else if (tick) begin
        if (db_cnt_reg == DB_LAST) begin
          key_db_reg <= key_s2_reg;
          db_cnt_reg <= 8'd0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 8'd1;
        end
      end
    end
  end

  // Pattern is right-aligned: first symbol keyed sits in bit cnt-1
  always_comb begin
    lut_char = 8'h3F;
    lut_ok   = 1'b1;
    case ({cnt_reg, pat_reg})
      {3'd1, 5'b00000}: lut_char = 8'h45; // E
      {3'd1, 5'b00001}: lut_char = 8'h54; // T
      {3'd2, 5'b00000}: lut_char = 8'h49; // I
      {3'd2, 5'b00001}: lut_char = 8'h41; // A
      {3'd2, 5'b00010}: lut_char = 8'h4E; // N
      {3'd2, 5'b00011}: lut_char = 8'h4D; // M
      {3'd3, 5'b00000}: lut_char = 8'h53; // S
      {3'd3, 5'b00001}: lut_char = 8'h55; // U
      {3'd3, 5'b00010}: lut_char = 8'h52; // R
      {3'd3, 5'b00011}: lut_char = 8'h57; // W
      {3'd3, 5'b00100}: lut_char = 8'h44; // D
      {3'd3, 5'b00101}: lut_char = 8'h4B; // K
      {3'd3, 5'b00110}: lut_char = 8'h47; // G
      {3'd3, 5'b00111}: lut_char = 8'h4F; // O
      {3'd4, 5'b00000}: lut_char = 8'h48; // H
      {3'd4, 5'b00001}: lut_char = 8'h56; // V
      {3'd4, 5'b00010}: lut_char = 8'h46; // F
      {3'd4, 5'b00100}: lut_char = 8'h4C; // L
      {3'd4, 5'b00110}: lut_char = 8'h50; // P
      {3'd4, 5'b00111}: lut_char = 8'h4A; // J
      {3'd4, 5'b01000}: lut_char = 8'h42; // B
      {3'd4, 5'b01001}: lut_char = 8'h58; // X
      {3'd4, 5'b01010}: lut_char = 8'h43; // C
      {3'd4, 5'b01011}: lut_char = 8'h59; // Y
      {3'd4, 5'b01100}: lut_char = 8'h5A; // Z
      {3'd4, 5'b01101}: lut_char = 8'h51; // Q
      {3'd5, 5'b11111}: lut_char = 8'h30;
      {3'd5, 5'b01111}: lut_char = 8'h31;
      {3'd5, 5'b00111}: lut_char = 8'h32;
      {3'd5, 5'b00011}: lut_char = 8'h33;
      {3'd5, 5'b00001}: lut_char = 8'h34;
      {3'd5, 5'b00000}: lut_char = 8'h35;
      {3'd5, 5'b10000}: lut_char = 8'h36;
      {3'd5, 5'b11000}: lut_char = 8'h37;
      {3'd5, 5'b11100}: lut_char = 8'h38;
      {3'd5, 5'b11110}: lut_char = 8'h39;
      default:          lut_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      dur_reg    <= 8'd0;
      gap_reg    <= 8'd0;
      pat_reg    <= 5'd0;
      cnt_reg    <= 3'd0;
      ovf_reg    <= 1'b0;
      letter_reg <= 8'h00;
      send_reg   <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dur_reg    <= dur_next;
      gap_reg    <= gap_next;
      pat_reg    <= pat_next;
      cnt_reg    <= cnt_next;
      ovf_reg    <= ovf_next;
      letter_reg <= letter_next;
      send_reg   <= send_next;
      error_reg  <= error_next;
    end
  end

  // Outputs are loaded on entry to EMIT so send/error/letter line up with that cycle
  always_comb begin
    state_next  = state_reg;
    dur_next    = dur_reg;
    gap_next    = gap_reg;
    pat_next    = pat_reg;
    cnt_next    = cnt_reg;
    ovf_next    = ovf_reg;
    letter_next = letter_reg;
    send_next   = 1'b0;
    error_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next = PRESS;
          dur_next   = 8'd0;
        end
      end
      PRESS: begin
        if (fall) begin
          if (cnt_reg < 3'd5) begin
            pat_next = {pat_reg[3:0], (dur_reg >= DOT_MAX)};
            cnt_next = cnt_reg + 3'd1;
          end else begin
            ovf_next = 1'b1;
          end
          state_next = GAP;
          gap_next   = 8'd0;
        end else if (tick && dur_reg != 8'hFF) begin
          dur_next = dur_reg + 8'd1;
        end
      end
      GAP: begin
        if (rise) begin
          state_next = PRESS;
          dur_next   = 8'd0;
        end else if (gap_reg >= GAP_END) begin
          state_next  = EMIT;
          send_next   = 1'b1;
          error_next  = ovf_reg | ~lut_ok;
          letter_next = (ovf_reg | ~lut_ok) ? 8'h3F : lut_char;
        end else if (tick && gap_reg != 8'hFF) begin
          gap_next = gap_reg + 8'd1;
        end
      end
      EMIT: begin
        state_next = IDLE;
        pat_next   = 5'd0;
        cnt_next   = 3'd0;
        ovf_next   = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  assign letter = letter_reg;
  assign send   = send_reg;
  assign error  = error_reg;
  assign busy   = (state_reg != IDLE);

endmodule
